// File: rtl/spdif_tx_feed_ctrl.sv
// Feed controller for the S/PDIF transmitter: bit-rate NCO plus a stereo sample FIFO
// that is drained one entry per core request, with silence or hold on underrun.
module spdif_tx_feed_ctrl #(
    parameter int          DEPTH         = 8,
    parameter logic [31:0] INC_44K1      = 32'd484884628,
    parameter logic [31:0] INC_48K       = 32'd527765581,
    parameter logic [31:0] INC_96K       = 32'd1055531162,
    parameter bit          UNDERRUN_HOLD = 1'b0,
    localparam int         LW            = $clog2(DEPTH + 1),
    localparam int         AW            = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic [1:0]    rate_sel_i,
    input  logic          mute_i,
    input  logic          wr_valid_i,
    input  logic [39:0]   wr_data_i,
    output logic          wr_ready_o,
    output logic          bit_out_en_o,
    output logic [39:0]   sample_o,
    input  logic          sample_req_i,
    output logic [LW-1:0] fifo_level_o,
    output logic          underrun_o,
    output logic [15:0]   underrun_cnt_o
);

    logic [31:0]   acc_r;
    logic [31:0]   inc_s;
    logic [32:0]   sum_s;
    logic [39:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    // Increment selection; both upper codes map to 96 kHz.
    always_comb begin
        inc_s = INC_96K;
        case (rate_sel_i)
            2'd0:    inc_s = INC_44K1;
            2'd1:    inc_s = INC_48K;
            default: inc_s = INC_96K;
        endcase
    end

    assign sum_s   = {1'b0, acc_r} + {1'b0, inc_s};
    assign full_s  = (level_r == LW'(DEPTH));
    assign empty_s = (level_r == {LW{1'b0}});
    // Decisions use the registered level only, so a same-cycle push never feeds a pop.
    assign push_s  = wr_valid_i && !full_s;
    assign pop_s   = sample_req_i && !empty_s;

    assign wr_ready_o   = !full_s;
    assign fifo_level_o = level_r;

    // Phase accumulator; the carry out becomes the registered bit enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_r        <= 32'd0;
            bit_out_en_o <= 1'b0;
        end else if (enable_i) begin
            acc_r        <= sum_s[31:0];
            bit_out_en_o <= sum_s[32];
        end else begin
            acc_r        <= 32'd0;
            bit_out_en_o <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data_i;
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (push_s && !pop_s) begin
                level_r <= level_r + LW'(1);
            end else if (pop_s && !push_s) begin
                level_r <= level_r - LW'(1);
            end else begin
                level_r <= level_r;
            end
        end
    end

    // Sample presentation and underrun reporting on each core request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_o       <= 40'd0;
            underrun_o     <= 1'b0;
            underrun_cnt_o <= 16'd0;
        end else begin
            underrun_o <= 1'b0;
            if (sample_req_i) begin
                if (!empty_s) begin
                    sample_o <= mute_i ? 40'd0 : mem_r[rd_ptr_r];
                end else begin
                    underrun_o <= 1'b1;
                    if (underrun_cnt_o != 16'hFFFF) begin
                        underrun_cnt_o <= underrun_cnt_o + 16'd1;
                    end
                    if (UNDERRUN_HOLD && !mute_i) begin
                        sample_o <= sample_o;
                    end else begin
                        sample_o <= 40'd0;
                    end
                end
            end
        end
    end

endmodule
